// File: rtl/output_drain_control.sv
// output_drain_control: de-skews per-lane array results into a local buffer and writes them word-by-word to L2.
// Optional OUTPUT_RELU_EN: negative results are written as zero.
module output_drain_control #(
    parameter int LANE_COUNT = 4,
    parameter int DATA_DEPTH = 8,
    parameter int OUT_DATAWIDTH = 32,
    parameter logic [31:0] L2_OUTPUT_ADDR = 32'h7000_0000
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     begin_drain,
    input  logic [LANE_COUNT-1:0]                    array_out_valid,
    input  logic [LANE_COUNT-1:0][OUT_DATAWIDTH-1:0] array_out,
    output logic [31:0]                              output_address,
    output logic [31:0]                              output_data,
    output logic                                     output_enable,
    output logic [3:0]                               output_write_en,
    output logic                                     drain_busy,
    output logic                                     outputs_stored,
    output logic                                     drain_overflow
);
    localparam int WORDS = LANE_COUNT * DATA_DEPTH;
    localparam int CW = $clog2(DATA_DEPTH) + 1;
    localparam int WW = $clog2(WORDS) + 1;
    localparam int KW = $clog2(DATA_DEPTH);
    localparam int IW = $clog2(LANE_COUNT);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITEBACK, DONE} state_t;
    state_t state, next_state;

    logic [CW-1:0] cnt [LANE_COUNT];
    logic [WW-1:0] wc;
    logic [OUT_DATAWIDTH-1:0] mem [DATA_DEPTH][LANE_COUNT];
    logic all_full, last_word;
    logic [KW-1:0] k_idx;
    logic [IW-1:0] i_idx;
    logic [OUT_DATAWIDTH-1:0] rd;
    logic [31:0] wdata;

    always_comb begin
        all_full = 1'b1;
        for (int i = 0; i < LANE_COUNT; i++) all_full &= cnt[i] == CW'(DATA_DEPTH);
    end

    assign last_word = wc == WW'(WORDS - 1);
    assign k_idx = KW'(wc / LANE_COUNT);
    assign i_idx = IW'(wc % LANE_COUNT);
    assign rd = mem[k_idx][i_idx];
`ifdef OUTPUT_RELU_EN
    assign wdata = rd[OUT_DATAWIDTH-1] ? 32'h0 : 32'($signed(rd));
`else
    assign wdata = 32'($signed(rd));
`endif
    assign drain_busy = state == COLLECT || state == WRITEBACK;

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= next_state;

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      next_state = begin_drain ? COLLECT : IDLE;
            COLLECT:   next_state = all_full ? WRITEBACK : COLLECT;
            WRITEBACK: next_state = last_word ? DONE : WRITEBACK;
            default:   next_state = IDLE;
        endcase
    end

    // Buffer holds data only; it is never reset.
    always_ff @(posedge clk)
        if (!rst && state == COLLECT)
            for (int i = 0; i < LANE_COUNT; i++)
                if (array_out_valid[i] && cnt[i] < CW'(DATA_DEPTH)) mem[cnt[i][KW-1:0]][i] <= array_out[i];

    always_ff @(posedge clk) begin
        if (rst) begin
            output_address <= '0;
            output_data <= '0;
            output_enable <= 1'b0;
            output_write_en <= '0;
            outputs_stored <= 1'b0;
            drain_overflow <= 1'b0;
            wc <= '0;
            for (int i = 0; i < LANE_COUNT; i++) cnt[i] <= '0;
        end else begin
            output_enable <= state == WRITEBACK;
            output_write_en <= state == WRITEBACK ? 4'hF : 4'h0;
            outputs_stored <= state == DONE;
            if (state == WRITEBACK) begin
                output_address <= L2_OUTPUT_ADDR + (32'(wc) << 2);
                output_data <= wdata;
                wc <= wc + 1'b1;
            end
            if (state == IDLE && begin_drain) begin
                drain_overflow <= 1'b0;
                wc <= '0;
                for (int i = 0; i < LANE_COUNT; i++) cnt[i] <= '0;
            end
            if (state == COLLECT)
                for (int i = 0; i < LANE_COUNT; i++)
                    if (array_out_valid[i]) begin
                        if (cnt[i] < CW'(DATA_DEPTH)) cnt[i] <= cnt[i] + 1'b1;
                        else drain_overflow <= 1'b1;
                    end
        end
    end
endmodule

// File: tb/tb_output_drain_control.sv
// tb_output_drain_control: scoreboard bench; a 32-bit and a 16-bit instance run in lockstep on the same strobes.
module tb_output_drain_control;
    localparam int L = 4, D = 8, N = 32;
    localparam logic [31:0] BASE = 32'h7000_0000;

    typedef struct {logic [31:0] a; logic [31:0] d;} exp_t;

    logic clk = 0, rst = 1, begin_drain = 0;
    logic [L-1:0] valid = '0;
    logic [L-1:0][31:0] aout = '0;
    logic [L-1:0][15:0] aout16;
    logic [31:0] output_address, output_data, a16, d16;
    logic output_enable, drain_busy, outputs_stored, drain_overflow;
    logic en16, busy16, stored16, ovf16;
    logic [3:0] output_write_en, we16;

    output_drain_control dut (
        .clk(clk), .rst(rst), .begin_drain(begin_drain), .array_out_valid(valid), .array_out(aout),
        .output_address(output_address), .output_data(output_data), .output_enable(output_enable),
        .output_write_en(output_write_en), .drain_busy(drain_busy), .outputs_stored(outputs_stored),
        .drain_overflow(drain_overflow));

    output_drain_control #(.OUT_DATAWIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .begin_drain(begin_drain), .array_out_valid(valid), .array_out(aout16),
        .output_address(a16), .output_data(d16), .output_enable(en16), .output_write_en(we16),
        .drain_busy(busy16), .outputs_stored(stored16), .drain_overflow(ovf16));

    always_comb for (int i = 0; i < L; i++) aout16[i] = aout[i][15:0];

    always #5 clk = ~clk;

    int cyc = 0, checks = 0, failures = 0, wr_cnt = 0, stored_cnt = 0, last_wr = 0, cap_cyc = 0;
    exp_t exp_q[$];
    exp_t me;
    logic [31:0] exp16_q[$];
    logic [31:0] vals [L][D];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, req);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef OUTPUT_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    // Monitor: pops and compares on every L2 write, and times the completion pulse.
    always @(negedge clk) begin
        if (output_enable) begin
            wr_cnt++;
            last_wr = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h/%h required=none", output_address, output_data);
            end else begin
                me = exp_q.pop_front();
                chk("addr", output_address, me.a);
                chk("data", output_data, me.d);
                chk("write_en", 32'(output_write_en), 32'hF);
                if (me.a == BASE) chk("first_write_latency", 32'(cyc - cap_cyc), 32'd2);
            end
        end
        if (en16) begin
            if (exp16_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write16 actual=%h required=none", d16);
            end else chk("data16", d16, exp16_q.pop_front());
        end
        if (outputs_stored) begin
            stored_cnt++;
            chk("stored_after_last_write", 32'(cyc - last_wr), 32'd1);
            chk("stored_enable_low", 32'(output_enable), 32'd0);
        end
    end

    task automatic fill_aligned();
        for (int i = 0; i < L; i++)
            for (int k = 0; k < D; k++) vals[i][k] = 32'(16 * i + k);
    endtask

    task automatic run_tile(input int skew, input bit ovf);
        logic [31:0] v;
        for (int w = 0; w < N; w++) begin
            v = vals[w % L][w / L];
            exp_q.push_back('{BASE + 32'(4 * w), relu(v)});
            exp16_q.push_back(relu(32'($signed(v[15:0]))));
        end
        @(negedge clk) begin_drain = 1;
        @(negedge clk) begin_drain = 0;
        chk("busy_after_begin", 32'(drain_busy), 32'd1);
        chk("ovf_cleared_on_begin", 32'(drain_overflow), 32'd0);
        for (int t = 0; t <= 3 * skew + 7; t++) begin
            for (int i = 0; i < L; i++) begin
                int k;
                k = t - i * skew;
                valid[i] = 1'b0;
                if (k >= 0 && k < D) begin
                    valid[i] = 1'b1;
                    aout[i] = vals[i][k];
                end else if (ovf && i == 2 && k == D) begin
                    valid[i] = 1'b1;
                    aout[i] = 32'h0BAD_0BAD;
                end
            end
            if (valid[3]) cap_cyc = cyc + 1;
            @(negedge clk);
        end
        valid = '0;
    endtask

    task automatic wait_writes(input int n);
        int s;
        s = wr_cnt;
        for (int c = 0; c < 200 && wr_cnt < s + n; c++) @(posedge clk);
        checks++;
        if (wr_cnt < s + n) begin
            failures++;
            $display("FAIL write_timeout actual=%0d required=%0d", wr_cnt - s, n);
        end
    endtask

    task automatic wait_done(input string n);
        int s0;
        bit ok;
        s0 = stored_cnt;
        ok = 0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(posedge clk);
            ok = stored_cnt != s0;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_done_timeout actual=no_pulse required=pulse", n);
        end
        repeat (3) @(negedge clk);
        chk({n, "_stored_once"}, 32'(stored_cnt - s0), 32'd1);
        chk({n, "_queue_empty"}, 32'(exp_q.size() + exp16_q.size()), 32'd0);
        chk({n, "_busy_low"}, 32'(drain_busy), 32'd0);
    endtask

    initial begin
        int s1, w1;
        repeat (3) @(negedge clk);
        chk("rst_addr", output_address, 32'h0);
        chk("rst_data", output_data, 32'h0);
        chk("rst_ctrl", {26'h0, output_enable, output_write_en, drain_busy}, 32'h0);
        chk("rst_flags", {30'h0, outputs_stored, drain_overflow}, 32'h0);
        rst = 0;

        fill_aligned();
        run_tile(0, 0);
        wait_done("aligned");

        // Strobes in IDLE must be ignored.
        valid = '1;
        repeat (3) @(negedge clk);
        valid = '0;
        chk("idle_busy", 32'(drain_busy), 32'd0);
        chk("idle_ovf", 32'(drain_overflow), 32'd0);

        run_tile(1, 0);
        wait_done("skewed");

        for (int i = 0; i < L; i++)
            for (int k = 0; k < D; k++) vals[i][k] = k[0] ? -32'(16 * i + k + 1) : 32'(16 * i + k);
        vals[0][0] = 32'h0000_FFFE;
        vals[1][1] = 32'hFFFF_FFFE;
        vals[3][7] = 32'h8000_0000;
        run_tile(2, 1);
        chk("ovf_set", 32'(drain_overflow), 32'd1);
        wait_done("overflow");
        chk("ovf_sticky", 32'(drain_overflow), 32'd1);

        fill_aligned();
        run_tile(0, 0);
        wait_writes(11);
        s1 = stored_cnt;
        @(negedge clk) rst = 1;
        @(negedge clk);
        chk("midrst_addr", output_address, 32'h0);
        chk("midrst_data", output_data, 32'h0);
        chk("midrst_ctrl", {26'h0, output_enable, output_write_en, drain_busy}, 32'h0);
        chk("midrst_flags", {30'h0, outputs_stored, drain_overflow}, 32'h0);
        exp_q.delete();
        exp16_q.delete();
        rst = 0;
        w1 = wr_cnt;
        repeat (40) @(negedge clk);
        chk("midrst_no_stored", 32'(stored_cnt - s1), 32'd0);
        chk("midrst_no_writes", 32'(wr_cnt - w1), 32'd0);
        run_tile(0, 0);
        wait_done("after_reset");

        run_tile(1, 0);
        wait_writes(5);
        @(negedge clk) begin_drain = 1;
        @(negedge clk) begin_drain = 0;
        wait_done("begin_in_wb");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
